// File: rtl/ecdsa_digest_loader_if.sv
// rtl/ecdsa_digest_loader_if.sv - digest word stream in, reduced z out
interface ecdsa_digest_loader_if #(
    parameter int WORD_W = 32
);
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ready;
    logic              z_valid;
    logic [255:0]      z_out;
    logic              z_ready;
    logic              z_reduced;

    modport master (
        output word_valid, word_data, z_ready,
        input  word_ready, z_valid, z_out, z_reduced
    );

    modport slave (
        input  word_valid, word_data, z_ready,
        output word_ready, z_valid, z_out, z_reduced
    );
endinterface

// File: rtl/ecdsa_digest_loader.sv
// rtl/ecdsa_digest_loader.sv - assembles the hash digest into z and reduces it once mod n
module ecdsa_digest_loader #(
    parameter int           WORD_W    = 32,
    parameter int           NUM_WORDS = 256 / WORD_W,
    parameter logic [255:0] N         = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141
) (
    input  logic                  clk,
    input  logic                  master_reset,
    input  logic                  load_hash,
    input  logic                  abort,
    output logic                  busy,
    ecdsa_digest_loader_if.slave  zif
);
    localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);

    // SUB registers the 257-bit difference so the borrow chain gets a full cycle
    // before REDUCE selects between z and z - N.
    typedef enum logic [2:0] {IDLE, COLLECT, SUB, REDUCE, PRESENT} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [255:0]     z;
    logic [256:0]     diff;
    logic             reduced;
    logic             clear;
    logic             accept;
    logic [255:0]     word_ext;

    assign word_ext = 256'(zif.word_data);

    always_ff @(posedge clk or negedge master_reset) begin
        if (!master_reset) state <= IDLE;
        else               state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        clear    = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (load_hash) begin
                    clear    = 1'b1;
                    state_nx = COLLECT;
                end
            end
            COLLECT: begin
                if (zif.word_valid) begin
                    accept = 1'b1;
                    if (cnt == LAST) state_nx = SUB;
                end
            end
            SUB:     state_nx = REDUCE;
            REDUCE:  state_nx = PRESENT;
            PRESENT: if (zif.z_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort) begin
            state_nx = IDLE;
            clear    = 1'b1;
            accept   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge master_reset) begin
        if (!master_reset) begin
            z       <= '0;
            cnt     <= '0;
            diff    <= '0;
            reduced <= 1'b0;
        end else if (clear) begin
            z       <= '0;
            cnt     <= '0;
            reduced <= 1'b0;
        end else begin
            if (accept) begin
                z   <= (z << WORD_W) | word_ext;
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
            if (state == SUB) diff <= {1'b0, z} - {1'b0, N};
            // No borrow out of bit 256 means z >= N; a single subtraction suffices since z < 2N.
            if (state == REDUCE && !diff[256]) begin
                z       <= diff[255:0];
                reduced <= 1'b1;
            end
        end
    end

    assign zif.word_ready = (state == COLLECT);
    assign zif.z_valid    = (state == PRESENT);
    assign zif.z_out      = z;
    assign zif.z_reduced  = reduced;
    assign busy           = (state != IDLE);
endmodule

// File: tb/tb_ecdsa_digest_loader.sv
// tb/tb_ecdsa_digest_loader.sv - table-driven and directed checks for ecdsa_digest_loader
module tb_ecdsa_digest_loader;
    localparam logic [255:0] N_C = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

    typedef struct {
        string        name;
        logic [255:0] digest;
        logic [255:0] exp_z;
        logic         exp_red;
        bit           gaps;
        bit           lh_mid;
        bit           hold;
    } vec_t;

    logic clk = 1'b0;
    logic master_reset = 1'b0;
    logic load_hash = 1'b0;
    logic abort = 1'b0;
    logic busy;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[7];

    ecdsa_digest_loader_if #(.WORD_W(32)) zif ();

    ecdsa_digest_loader #(.WORD_W(32)) dut (
        .clk          (clk),
        .master_reset (master_reset),
        .load_hash    (load_hash),
        .abort        (abort),
        .busy         (busy),
        .zif          (zif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start(output int c0);
        @(negedge clk);
        load_hash = 1'b1;
        @(negedge clk);
        load_hash = 1'b0;
        c0 = cyc;
    endtask

    task automatic feed(input logic [255:0] d, input bit gaps, input int nwords, input bit lh_mid);
        for (int i = 0; i < nwords; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                zif.word_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            zif.word_valid = 1'b1;
            zif.word_data  = d[255-32*i -: 32];
            load_hash      = lh_mid && (i == 3);
            @(negedge clk);
        end
        zif.word_valid = 1'b0;
        zif.word_data  = '0;
        load_hash      = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int c0, output int lat);
        int n = 0;
        while (zif.z_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        lat = cyc - c0;
        chk({name, " z_valid reached"}, 256'(zif.z_valid), 256'd1);
    endtask

    task automatic no_zvalid(input string name, input int ncyc);
        bit seen = 1'b0;
        repeat (ncyc) begin
            @(negedge clk);
            if (zif.z_valid !== 1'b0) seen = 1'b1;
        end
        chk({name, " no z_valid pulse"}, 256'(seen), 256'd0);
    endtask

    task automatic handshake(input string name, input logic [255:0] exp_z, input logic exp_red);
        zif.z_ready = 1'b1;
        load_hash   = 1'b1;
        @(negedge clk);
        zif.z_ready = 1'b0;
        load_hash   = 1'b0;
        chk({name, " z_valid after handshake"}, 256'(zif.z_valid), 256'd0);
        chk({name, " busy after handshake"}, 256'(busy), 256'd0);
        chk({name, " z_out retained"}, zif.z_out, exp_z);
        chk({name, " z_reduced retained"}, 256'(zif.z_reduced), 256'(exp_red));
        @(negedge clk);
        chk({name, " load_hash on handshake ignored"}, 256'(busy), 256'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int c0;
        int lat;
        start(c0);
        chk({v.name, " busy after load"}, 256'(busy), 256'd1);
        chk({v.name, " word_ready after load"}, 256'(zif.word_ready), 256'd1);
        feed(v.digest, v.gaps, 8, v.lh_mid);
        wait_valid(v.name, c0, lat);
        if (!v.gaps) chk({v.name, " latency"}, 256'(lat), 256'd10);
        chk({v.name, " z_out"}, zif.z_out, v.exp_z);
        chk({v.name, " z_reduced"}, 256'(zif.z_reduced), 256'(v.exp_red));
        chk({v.name, " word_ready in present"}, 256'(zif.word_ready), 256'd0);
        if (v.hold) begin
            for (int k = 0; k < 5; k++) begin
                load_hash = (k == 2);
                @(negedge clk);
                chk({v.name, " hold z_valid"}, 256'(zif.z_valid), 256'd1);
                chk({v.name, " hold z_out"}, zif.z_out, v.exp_z);
            end
            load_hash = 1'b0;
        end
        handshake(v.name, v.exp_z, v.exp_red);
    endtask

    initial begin
        int c0;
        int lat;
        vecs[0] = '{name:"alt", digest:{4{64'h01234567_89ABCDEF}}, exp_z:{4{64'h01234567_89ABCDEF}},
                    exp_red:1'b0, gaps:1'b0, lh_mid:1'b0, hold:1'b0};
        vecs[1] = '{name:"ones", digest:{8{32'hFFFFFFFF}},
                    exp_z:256'h00000000_00000000_00000000_00000001_45512319_50B75FC4_402DA173_2FC9BEBE,
                    exp_red:1'b1, gaps:1'b0, lh_mid:1'b0, hold:1'b1};
        vecs[2] = '{name:"eq_n", digest:N_C, exp_z:256'd0, exp_red:1'b1, gaps:1'b0, lh_mid:1'b0, hold:1'b0};
        vecs[3] = '{name:"n_minus_1", digest:N_C - 256'd1,
                    exp_z:256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364140,
                    exp_red:1'b0, gaps:1'b0, lh_mid:1'b0, hold:1'b0};
        vecs[4] = '{name:"zero", digest:256'd0, exp_z:256'd0, exp_red:1'b0, gaps:1'b0, lh_mid:1'b1, hold:1'b0};
        vecs[5] = '{name:"gaps_alt", digest:{4{64'h01234567_89ABCDEF}}, exp_z:{4{64'h01234567_89ABCDEF}},
                    exp_red:1'b0, gaps:1'b1, lh_mid:1'b1, hold:1'b1};
        vecs[6] = '{name:"gaps_n_plus_5", digest:N_C + 256'd5, exp_z:256'd5, exp_red:1'b1,
                    gaps:1'b1, lh_mid:1'b0, hold:1'b0};

        zif.word_valid = 1'b0;
        zif.word_data  = '0;
        zif.z_ready    = 1'b0;
        #1;
        chk("reset busy", 256'(busy), 256'd0);
        chk("reset word_ready", 256'(zif.word_ready), 256'd0);
        chk("reset z_valid", 256'(zif.z_valid), 256'd0);
        chk("reset z_out", zif.z_out, 256'd0);
        chk("reset z_reduced", 256'(zif.z_reduced), 256'd0);
        @(negedge clk);
        @(negedge clk);
        master_reset = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Asynchronous reset in the middle of COLLECT, then a clean capture.
        start(c0);
        feed({8{32'h89ABCDEF}}, 1'b0, 3, 1'b0);
        #2 master_reset = 1'b0;
        #1;
        chk("async rst busy", 256'(busy), 256'd0);
        chk("async rst word_ready", 256'(zif.word_ready), 256'd0);
        chk("async rst z_valid", 256'(zif.z_valid), 256'd0);
        chk("async rst z_out", zif.z_out, 256'd0);
        chk("async rst z_reduced", 256'(zif.z_reduced), 256'd0);
        @(negedge clk);
        @(negedge clk);
        master_reset = 1'b1;
        start(c0);
        feed({8{32'h00000001}}, 1'b0, 8, 1'b0);
        wait_valid("post_rst", c0, lat);
        chk("post_rst z_out", zif.z_out, {8{32'h00000001}});
        chk("post_rst z_reduced", 256'(zif.z_reduced), 256'd0);
        handshake("post_rst", {8{32'h00000001}}, 1'b0);

        // Abort during COLLECT, with a word offered on the same edge.
        start(c0);
        feed({8{32'hFFFFFFFF}}, 1'b0, 3, 1'b0);
        abort          = 1'b1;
        zif.word_valid = 1'b1;
        zif.word_data  = 32'h12345678;
        @(negedge clk);
        abort          = 1'b0;
        zif.word_valid = 1'b0;
        chk("abort collect busy", 256'(busy), 256'd0);
        chk("abort collect z_out", zif.z_out, 256'd0);
        no_zvalid("abort collect", 12);

        // Abort during the reduction cycles.
        start(c0);
        feed({8{32'hFFFFFFFF}}, 1'b0, 8, 1'b0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort reduce busy", 256'(busy), 256'd0);
        chk("abort reduce z_out", zif.z_out, 256'd0);
        chk("abort reduce z_reduced", 256'(zif.z_reduced), 256'd0);
        no_zvalid("abort reduce", 12);

        // Abort together with load_hash while presenting a reduced result.
        start(c0);
        feed({8{32'hFFFFFFFF}}, 1'b0, 8, 1'b0);
        wait_valid("abort present", c0, lat);
        chk("abort present pre z_reduced", 256'(zif.z_reduced), 256'd1);
        abort     = 1'b1;
        load_hash = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        load_hash = 1'b0;
        chk("abort present busy", 256'(busy), 256'd0);
        chk("abort present z_valid", 256'(zif.z_valid), 256'd0);
        chk("abort present z_out", zif.z_out, 256'd0);
        chk("abort present z_reduced", 256'(zif.z_reduced), 256'd0);
        no_zvalid("abort present", 4);
        chk("abort+load stays idle", 256'(busy), 256'd0);

        run_vec(vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
